// File: rtl/cordic_axi4s_types_pkg.sv
// Shared types for the CORDIC AXI4-Stream client arbiter: vector-selection
// encoding and requester-index sizing.
package cordic_axi4s_types_pkg;

    typedef enum logic {
        CORDIC_SINE_COSINE_E = 1'b0,
        CORDIC_ATAN_MAG_E    = 1'b1
    } cordic_vec_sel_e;

    // A single requester still needs one index bit.
    function automatic int unsigned req_idx_width(input int unsigned nr_of_requesters);
        return (nr_of_requesters < 2) ? 1 : $clog2(nr_of_requesters);
    endfunction

endpackage

// File: rtl/cordic_axi4s_arbiter_if.sv
// Bundle of request, result and CORDIC-side AXI4-Stream signals around the
// shared CORDIC arbiter; slave is the arbiter's view, master the environment's.
interface cordic_axi4s_arbiter_if #(
    parameter int unsigned NR_OF_REQUESTERS_P = 4,
    parameter int unsigned AXI_DATA_WIDTH_P   = 32,
    parameter int unsigned AXI_ID_WIDTH_P     = 4
);
    logic [NR_OF_REQUESTERS_P-1:0]                    req_tvalid;
    logic [NR_OF_REQUESTERS_P-1:0]                    req_tready;
    logic [NR_OF_REQUESTERS_P*AXI_DATA_WIDTH_P-1:0]   req_tdata;
    logic [NR_OF_REQUESTERS_P*AXI_ID_WIDTH_P-1:0]     req_tid;
    logic [NR_OF_REQUESTERS_P-1:0]                    req_tuser;
    logic [NR_OF_REQUESTERS_P-1:0]                    req_tlast;

    logic [NR_OF_REQUESTERS_P-1:0]                    rsp_tvalid;
    logic [NR_OF_REQUESTERS_P-1:0]                    rsp_tready;
    logic [NR_OF_REQUESTERS_P*2*AXI_DATA_WIDTH_P-1:0] rsp_tdata;
    logic [NR_OF_REQUESTERS_P-1:0]                    rsp_tlast;

    logic                                             cordic_egr_tvalid;
    logic                                             cordic_egr_tready;
    logic [AXI_DATA_WIDTH_P-1:0]                      cordic_egr_tdata;
    logic [AXI_ID_WIDTH_P-1:0]                        cordic_egr_tid;
    logic                                             cordic_egr_tuser;
    logic                                             cordic_egr_tlast;

    logic                                             cordic_ing_tvalid;
    logic                                             cordic_ing_tready;
    logic [2*AXI_DATA_WIDTH_P-1:0]                    cordic_ing_tdata;
    logic                                             cordic_ing_tlast;

    modport slave (
        input  req_tvalid, req_tdata, req_tid, req_tuser, req_tlast,
        output req_tready,
        output rsp_tvalid, rsp_tdata, rsp_tlast,
        input  rsp_tready,
        output cordic_egr_tvalid, cordic_egr_tdata, cordic_egr_tid, cordic_egr_tuser, cordic_egr_tlast,
        input  cordic_egr_tready,
        input  cordic_ing_tvalid, cordic_ing_tdata, cordic_ing_tlast,
        output cordic_ing_tready
    );

    modport master (
        output req_tvalid, req_tdata, req_tid, req_tuser, req_tlast,
        input  req_tready,
        input  rsp_tvalid, rsp_tdata, rsp_tlast,
        output rsp_tready,
        input  cordic_egr_tvalid, cordic_egr_tdata, cordic_egr_tid, cordic_egr_tuser, cordic_egr_tlast,
        output cordic_egr_tready,
        output cordic_ing_tvalid, cordic_ing_tdata, cordic_ing_tlast,
        input  cordic_ing_tready
    );

endinterface

// File: rtl/cordic_arb_tag_fifo.sv
// In-order tag FIFO holding the requester index of each request issued to the
// CORDIC; head data is valid combinationally while not empty.
module cordic_arb_tag_fifo #(
    parameter int unsigned WIDTH_P = 2,
    parameter int unsigned DEPTH_P = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH_P-1:0]         push_data,
    input  logic                       pop,
    output logic [WIDTH_P-1:0]         head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH_P):0]   fill
);
    localparam int unsigned PTR_W = $clog2(DEPTH_P);

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (count == (PTR_W+1)'(DEPTH_P));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign fill      = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cordic_axi4s_arbiter.sv
// Round-robin sharing of one pipelined CORDIC between several AXI4-Stream
// clients; results are steered back in issue order via a tag FIFO.
module cordic_axi4s_arbiter
    import cordic_axi4s_types_pkg::*;
#(
    parameter int unsigned NR_OF_REQUESTERS_P = 4,
    parameter int unsigned AXI_DATA_WIDTH_P   = 32,
    parameter int unsigned AXI_ID_WIDTH_P     = 4,
    parameter int unsigned TAG_FIFO_DEPTH_P   = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    cordic_axi4s_arbiter_if.slave             bus,
    output logic [$clog2(TAG_FIFO_DEPTH_P):0] sr_outstanding,
    output logic                              sr_unexpected_rsp
);
    localparam int unsigned REQ_IDX_WIDTH_C = req_idx_width(NR_OF_REQUESTERS_P);
    localparam int unsigned N   = NR_OF_REQUESTERS_P;
    localparam int unsigned W   = AXI_DATA_WIDTH_P;
    localparam int unsigned IDW = AXI_ID_WIDTH_P;
    localparam int unsigned IW  = REQ_IDX_WIDTH_C;

    localparam logic EGR_EMPTY = 1'b0;
    localparam logic EGR_FULL  = 1'b1;

    logic           egr_state_q;
    logic           egr_state_d;
    logic [W-1:0]   egr_tdata_q;
    logic [IDW-1:0] egr_tid_q;
    logic           egr_tuser_q;
    logic           egr_tlast_q;
    logic [IW-1:0]  rr_ptr_q;
    logic           unexpected_q;

    logic           egress_free_c;
    logic           grant_valid_c;
    logic [IW-1:0]  grant_idx_c;
    logic           accept_c;
    logic [N-1:0]   req_tready_c;
    logic [N-1:0]   rsp_tvalid_c;
    logic [N-1:0]   rsp_tlast_c;
    logic           ing_tready_c;
    logic           ing_pop_c;
    logic           tag_full;
    logic           tag_empty;
    logic [IW-1:0]  tag_head;

    assign egress_free_c = (egr_state_q == EGR_EMPTY) || bus.cordic_egr_tready;
    assign accept_c      = grant_valid_c && egress_free_c && !tag_full;

    // First valid requester at or after rr_ptr, modulo N.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_idx_c   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (!grant_valid_c && bus.req_tvalid[IW'((int'(rr_ptr_q) + i) % int'(N))]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = IW'((int'(rr_ptr_q) + i) % int'(N));
            end
        end
    end

    always_comb begin
        req_tready_c = '0;
        if (accept_c) req_tready_c[grant_idx_c] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) egr_state_q <= EGR_EMPTY;
        else        egr_state_q <= egr_state_d;
    end

    always_comb begin
        egr_state_d = egr_state_q;
        case (egr_state_q)
            EGR_EMPTY: if (accept_c) egr_state_d = EGR_FULL;
            EGR_FULL:  if (bus.cordic_egr_tready && !accept_c) egr_state_d = EGR_EMPTY;
            default:   egr_state_d = EGR_EMPTY;
        endcase
    end

    // Payload only moves on accept, so it holds while the CORDIC stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            egr_tdata_q <= '0;
            egr_tid_q   <= '0;
            egr_tuser_q <= CORDIC_SINE_COSINE_E;
            egr_tlast_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else if (accept_c) begin
            egr_tdata_q <= bus.req_tdata[grant_idx_c*W +: W];
            egr_tid_q   <= bus.req_tid[grant_idx_c*IDW +: IDW];
            egr_tuser_q <= bus.req_tuser[grant_idx_c];
            egr_tlast_q <= bus.req_tlast[grant_idx_c];
            rr_ptr_q    <= (grant_idx_c == IW'(N - 1)) ? '0 : grant_idx_c + IW'(1);
        end
    end

    // With no tag outstanding, results are swallowed rather than stalling the CORDIC.
    always_comb begin
        rsp_tvalid_c = '0;
        rsp_tlast_c  = '0;
        ing_tready_c = 1'b1;
        if (!tag_empty) begin
            rsp_tvalid_c[tag_head] = bus.cordic_ing_tvalid;
            rsp_tlast_c[tag_head]  = bus.cordic_ing_tlast;
            ing_tready_c           = bus.rsp_tready[tag_head];
        end
    end

    assign ing_pop_c = !tag_empty && bus.cordic_ing_tvalid && bus.rsp_tready[tag_head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                unexpected_q <= 1'b0;
        else if (tag_empty && bus.cordic_ing_tvalid) unexpected_q <= 1'b1;
    end

    cordic_arb_tag_fifo #(
        .WIDTH_P (IW),
        .DEPTH_P (TAG_FIFO_DEPTH_P)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept_c),
        .push_data (grant_idx_c),
        .pop       (ing_pop_c),
        .head_data (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .fill      (sr_outstanding)
    );

    assign bus.req_tready        = req_tready_c;
    assign bus.rsp_tvalid        = rsp_tvalid_c;
    assign bus.rsp_tlast         = rsp_tlast_c;
    assign bus.rsp_tdata         = {N{bus.cordic_ing_tdata}};
    assign bus.cordic_ing_tready = ing_tready_c;
    assign bus.cordic_egr_tvalid = (egr_state_q == EGR_FULL);
    assign bus.cordic_egr_tdata  = egr_tdata_q;
    assign bus.cordic_egr_tid    = egr_tid_q;
    assign bus.cordic_egr_tuser  = egr_tuser_q;
    assign bus.cordic_egr_tlast  = egr_tlast_q;
    assign sr_unexpected_rsp     = unexpected_q;

endmodule
